// File: rtl/factorize_search_ctrl_if.sv
// Control/result bundle for factorize_search_ctrl.
// Also carries the controller state as a read-only debug field.
interface factorize_search_ctrl_if #(
  parameter int A_W = 5,
  parameter int B_W = 3
);
  // start: level request, accepted only in IDLE. abort: honoured only while busy.
  // done: single-cycle pulse. sat/a_out/b_out hold until the next accepted start.
  logic               start;
  logic               abort;
  logic               busy;
  logic               done;
  logic               sat;
  logic [A_W-1:0]     a_out;
  logic [B_W-1:0]     b_out;
  logic [A_W+B_W-1:0] cand_count;
  logic [1:0]         state;

  modport master (
    output start, abort,
    input  busy, done, sat, a_out, b_out, cand_count, state
  );

  modport slave (
    input  start, abort,
    output busy, done, sat, a_out, b_out, cand_count, state
  );
endinterface

// File: rtl/factorize_search_ctrl.sv
// Searches for TARGET = a * b (a, b > 1) using one iterative shift-add multiplier.
// Define FACT_ODD_ONLY_EN to enumerate only odd candidates (odd TARGET only).
module factorize_search_ctrl #(
  parameter int                   A_W    = 5,
  parameter int                   B_W    = 3,
  parameter logic [A_W+B_W-1:0]   TARGET = 37
) (
  input logic                     clk,
  input logic                     rst_n,
  factorize_search_ctrl_if.slave  bus
);
  localparam int P_W   = A_W + B_W;
  localparam int BIT_W = (B_W > 1) ? $clog2(B_W) : 1;
`ifdef FACT_ODD_ONLY_EN
  localparam int A_MIN = 3;
  localparam int B_MIN = 3;
  localparam int STEP  = 2;
  if (TARGET[0] == 1'b0) begin : g_even_target
    $error("factorize_search_ctrl: odd-only search requires an odd TARGET");
  end
`else
  localparam int A_MIN = 2;
  localparam int B_MIN = 2;
  localparam int STEP  = 1;
`endif
  localparam logic [A_W-1:0] A_MAX = '1;
  localparam logic [B_W-1:0] B_MAX = '1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_CHECK = 2'd2} state_t;

  state_t             state, state_next;
  logic [P_W-1:0]     acc;
  logic [BIT_W-1:0]   bit_idx;
  logic [A_W-1:0]     a_cur;
  logic [B_W-1:0]     b_cur;
  logic               sat, done;
  logic [A_W-1:0]     a_out;
  logic [B_W-1:0]     b_out;
  logic [P_W-1:0]     cand_count;

  logic last_bit, last_cand, match;
  logic busy, load, count, finish, advance;

  assign last_bit  = (bit_idx == BIT_W'(B_W - 1));
  assign last_cand = (a_cur == A_MAX) && (b_cur == B_MAX);
  assign match     = (acc == TARGET);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (bus.start) state_next = S_MUL;
      S_MUL:   if (bus.abort) state_next = S_IDLE;
               else if (last_bit) state_next = S_CHECK;
      S_CHECK: if (bus.abort) state_next = S_IDLE;
               else if (match || last_cand) state_next = S_IDLE;
               else state_next = S_MUL;
      default: state_next = S_IDLE;
    endcase
  end

  // Abort outranks a same-cycle match, so every CHECK action is gated by it.
  always_comb begin
    busy    = (state != S_IDLE);
    load    = (state == S_IDLE) && bus.start;
    count   = (state == S_CHECK) && !bus.abort;
    finish  = count && (match || last_cand);
    advance = count && !match && !last_cand;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      bit_idx    <= '0;
      a_cur      <= '0;
      b_cur      <= '0;
      sat        <= 1'b0;
      done       <= 1'b0;
      a_out      <= '0;
      b_out      <= '0;
      cand_count <= '0;
    end else begin
      done <= finish;
      if (load) begin
        a_cur      <= A_W'(A_MIN);
        b_cur      <= B_W'(B_MIN);
        acc        <= '0;
        bit_idx    <= '0;
        sat        <= 1'b0;
        a_out      <= '0;
        b_out      <= '0;
        cand_count <= '0;
      end
      if (state == S_MUL) begin
        if (b_cur[bit_idx]) acc <= acc + (P_W'(a_cur) << bit_idx);
        bit_idx <= bit_idx + 1'b1;
      end
      if (count && (cand_count != '1)) cand_count <= cand_count + 1'b1;
      if (finish) begin
        sat <= match;
        if (match) begin
          a_out <= a_cur;
          b_out <= b_cur;
        end
      end
      if (busy && bus.abort) sat <= 1'b0;
      if (advance) begin
        acc     <= '0;
        bit_idx <= '0;
        if (a_cur == A_MAX) begin
          a_cur <= A_W'(A_MIN);
          b_cur <= b_cur + B_W'(STEP);
        end else begin
          a_cur <= a_cur + A_W'(STEP);
        end
      end
    end
  end

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.sat        = sat;
  assign bus.a_out      = a_out;
  assign bus.b_out      = b_out;
  assign bus.cand_count = cand_count;
  assign bus.state      = state;
endmodule

// File: tb/tb_factorize_search_ctrl.sv
// Bench for factorize_search_ctrl: four instances (TARGET 37, 35, 9, 3) driven
// from a table of directed runs plus hand-written reset sequences.
module tb_factorize_search_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start_v [4];
  logic       abort_v [4];
  logic       busy_v  [4];
  logic       done_v  [4];
  logic       sat_v   [4];
  logic [4:0] a_v     [4];
  logic [2:0] b_v     [4];
  logic [7:0] cnt_v   [4];
  logic [1:0] st_v    [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam logic [7:0] TGT = (g == 0) ? 8'd37 : (g == 1) ? 8'd35 : (g == 2) ? 8'd9 : 8'd3;
    factorize_search_ctrl_if #(.A_W(5), .B_W(3)) bus ();
    assign bus.start  = start_v[g];
    assign bus.abort  = abort_v[g];
    assign busy_v[g]  = bus.busy;
    assign done_v[g]  = bus.done;
    assign sat_v[g]   = bus.sat;
    assign a_v[g]     = bus.a_out;
    assign b_v[g]     = bus.b_out;
    assign cnt_v[g]   = bus.cand_count;
    assign st_v[g]    = bus.state;
    factorize_search_ctrl #(.A_W(5), .B_W(3), .TARGET(TGT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  typedef struct {
    int idx;
    int abort_at;
    int poke_at;
    int chain;
    int exp_edges;
    int exp_sat;
    int exp_a;
    int exp_b;
    int exp_cnt;
  } vec_t;

  vec_t vecs [8];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    bit got_done;
    bit busy_ok;
    start_v[v.idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[v.idx] = 1'b0;
    check("cnt_cleared_on_start", cnt_v[v.idx], 0);
    k = 0;
    got_done = 1'b0;
    busy_ok = 1'b1;
    while (!got_done && k < 1000) begin
      if (v.abort_at != 0 && k == v.abort_at - 1) abort_v[v.idx] = 1'b1;
      if (v.poke_at != 0 && k == v.poke_at) start_v[v.idx] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      k++;
      abort_v[v.idx] = 1'b0;
      start_v[v.idx] = 1'b0;
      if (v.abort_at != 0 && k == v.abort_at) break;
      if (done_v[v.idx]) got_done = 1'b1;
      else if (!busy_v[v.idx]) busy_ok = 1'b0;
    end
    check("busy_during_search", busy_ok, 1);
    if (v.abort_at != 0) begin
      int n_done;
      check("abort_busy", busy_v[v.idx], 0);
      check("abort_done", done_v[v.idx], 0);
      check("abort_sat", sat_v[v.idx], 0);
      check("abort_cnt", cnt_v[v.idx], v.exp_cnt);
      n_done = 0;
      repeat (20) begin
        @(negedge clk);
        if (done_v[v.idx]) n_done++;
      end
      check("abort_no_done", n_done, 0);
    end else begin
      check("done_edge", k, v.exp_edges);
      check("busy_at_done", busy_v[v.idx], 0);
      check("sat", sat_v[v.idx], v.exp_sat);
      check("a_out", a_v[v.idx], v.exp_a);
      check("b_out", b_v[v.idx], v.exp_b);
      check("cand_count", cnt_v[v.idx], v.exp_cnt);
      if (v.chain == 0) begin
        // Idle cycle after done; abort here must be a no-op.
        abort_v[v.idx] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort_v[v.idx] = 1'b0;
        check("done_one_cycle", done_v[v.idx], 0);
        check("sat_hold", sat_v[v.idx], v.exp_sat);
        check("a_hold", a_v[v.idx], v.exp_a);
        check("idle_stays_idle", busy_v[v.idx], 0);
      end
    end
  endtask

  initial begin
`ifdef FACT_ODD_ONLY_EN
    vecs[0] = '{0, 0,  0, 0, 180, 0, 0, 0, 45};
    vecs[1] = '{1, 0, 10, 0,  72, 1, 7, 5, 18};
    vecs[2] = '{2, 0,  0, 1,   4, 1, 3, 3,  1};
    vecs[3] = '{2, 0,  0, 0,   4, 1, 3, 3,  1};
    vecs[4] = '{3, 0,  0, 0, 180, 0, 0, 0, 45};
    vecs[5] = '{0, 50, 0, 0,   0, 0, 0, 0, 12};
    vecs[6] = '{0, 0,  0, 0, 180, 0, 0, 0, 45};
    vecs[7] = '{2, 4,  0, 0,   0, 0, 0, 0,  0};
`else
    vecs[0] = '{0, 0,  0, 0, 720, 0, 0, 0, 180};
    vecs[1] = '{1, 0, 10, 0, 384, 1, 7, 5,  96};
    vecs[2] = '{2, 0,  0, 1, 128, 1, 3, 3,  32};
    vecs[3] = '{2, 0,  0, 0, 128, 1, 3, 3,  32};
    vecs[4] = '{3, 0,  0, 0, 720, 0, 0, 0, 180};
    vecs[5] = '{0, 50, 0, 0,   0, 0, 0, 0,  12};
    vecs[6] = '{0, 0,  0, 0, 720, 0, 0, 0, 180};
    vecs[7] = '{2, 128, 0, 0,  0, 0, 0, 0,  31};
`endif
    for (int i = 0; i < 4; i++) begin
      start_v[i] = 1'b0;
      abort_v[i] = 1'b0;
    end

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy_v[0], 0);
    check("rst_done", done_v[0], 0);
    check("rst_sat", sat_v[0], 0);
    check("rst_a_out", a_v[0], 0);
    check("rst_b_out", b_v[0], 0);
    check("rst_cnt", cnt_v[0], 0);
    check("rst_state", st_v[0], 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
      if (vecs[i].chain == 0) @(negedge clk);
    end

    // Asynchronous reset in the middle of a MUL phase.
    start_v[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[1] = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("pre_reset_cnt", cnt_v[1], 1);
    check("pre_reset_busy", busy_v[1], 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy_v[1], 0);
    check("async_rst_done", done_v[1], 0);
    check("async_rst_sat", sat_v[1], 0);
    check("async_rst_a_out", a_v[1], 0);
    check("async_rst_b_out", b_v[1], 0);
    check("async_rst_cnt", cnt_v[1], 0);
    check("async_rst_state", st_v[1], 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", busy_v[1], 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
